mdu_ctrl: RTL
=============

Name: mdu_ctrl

Overview:
- Sequencer for the EXE-stage multiply/divide resource: the 33-bit signed multiplier, the signed and unsigned divider IPs (AXI-stream style), and the HI/LO register write port.
- Accepts one MDU operation from EXE and latches its operands.
- Drives the divider valid/ready handshakes and counts multiplier latency.
- Stalls EXE while busy, writes HI/LO exactly once per completed operation, and discards in-flight results on exception flush.

Parameters:
- MUL_STAGES, 1, multiplier latency in cycles from operand presentation to valid mul_prod (legal 1..7).

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- req_valid  in  1  EXE holds a valid MDU op; held stable until done.
- req_op  in  3  001 mult, 010 multu, 011 div, 100 divu, 101 mthi, 110 mtlo, others none.
- req_src1  in  32  rs operand / dividend.
- req_src2  in  32  rt operand / divisor.
- flush  in  1  exception flush from WB.
- busy_stall  out  1  hold EXE.
- done  out  1  one-cycle completion pulse.
- op_a  out  32  operand A to multiplier/dividers.
- op_b  out  32  operand B to multiplier/dividers.
- mul_signed  out  1  1 = signed-extend multiplier operands.
- mul_prod  in  64  multiplier product.
- divs_tvalid  out  1  signed divider input valid (dividend and divisor together).
- divs_tready  in  1  signed divider input ready.
- divs_dout_valid  in  1  signed divider result valid.
- divs_dout  in  64  {quotient[63:32], remainder[31:0]}.
- divu_tvalid  out  1  unsigned divider input valid.
- divu_tready  in  1  unsigned divider input ready.
- divu_dout_valid  in  1  unsigned divider result valid.
- divu_dout  in  64  {quotient[63:32], remainder[31:0]}.
- hl_we  out  2  {hi_we, lo_we}.
- hi_wdata  out  32  HI write data.
- lo_wdata  out  32  LO write data.

Behaviour:
- States: IDLE, MUL_WAIT, DIV_SEND, DIV_WAIT, DRAIN.
- Reset: state IDLE, counter 0, latched operands 0. All outputs 0 (busy_stall, done, tvalids, hl_we, data, mul_signed). The divider IPs share this reset, so no drain is performed on reset.
- Operand outputs:
  - In IDLE, op_a/op_b pass req_src1/req_src2 through combinationally.
  - In all other states they come from registers latched at acceptance.
  - mul_signed = 1 for op mult, latched the same way.
- Acceptance happens in IDLE when req_valid & ~flush & op legal. flush has priority: a request arriving with flush is not accepted.
- mthi/mtlo:
  - Complete in the acceptance cycle with no stall.
  - done=1; hl_we=10 with hi_wdata=req_src1 (mthi), or hl_we=01 with lo_wdata=req_src1 (mtlo).
  - State stays IDLE.
- mult/multu:
  - Acceptance cycle T0: busy_stall=1, counter loaded with MUL_STAGES-1, next state MUL_WAIT. If MUL_STAGES=1, the write happens in T0+1.
  - MUL_WAIT: busy_stall=1 while counter≠0; counter decrements each cycle.
  - Completion at cycle T0+MUL_STAGES: hl_we=11, hi=mul_prod[63:32], lo=mul_prod[31:0], done=1, busy_stall=0, next IDLE.
- div/divu:
  - Acceptance: busy_stall=1, next DIV_SEND.
  - DIV_SEND: the selected tvalid=1 (never both) and is held until the cycle where tready=1 (the handshake). Next state DIV_WAIT; tvalid drops the following cycle.
  - DIV_WAIT: busy_stall=1 until the selected dout_valid. On that cycle: hl_we=11, hi=dout[31:0] (remainder), lo=dout[63:32] (quotient), done=1, busy_stall=0, next IDLE.
  - Divide by zero raises no exception; the IP result is written as-is.
  - A dout_valid from the non-selected divider is ignored.
- flush:
  - MUL_WAIT → IDLE, no write.
  - DIV_SEND with no handshake this cycle → IDLE, tvalid deasserted next cycle.
  - DIV_SEND with handshake in the same cycle, or DIV_WAIT → DRAIN, remembering which divider.
  - DRAIN: wait for that divider's dout_valid, discard it (hl_we=0, done=0), then → IDLE.
  - In DRAIN, busy_stall = req_valid; new requests are not accepted until IDLE.
  - A flush during DRAIN is ignored.
- Stray dout_valid in IDLE is ignored.
- hl_we is never nonzero outside the completion cycles above; done and hl_we≠0 always coincide.

Test Plan:
- mult, src1=0xFFFFFFFE, src2=3, MUL_STAGES=1 → busy_stall=1 for 1 cycle; next cycle hl_we=11, HI=0xFFFFFFFF, LO=0xFFFFFFFA, done=1.
- multu with the same operands → HI=0x00000002, LO=0xFFFFFFFA.
- div, src1=-7, src2=2; divs_tready low 3 cycles, then high; dout_valid 20 cycles later with {0xFFFFFFFD,0xFFFFFFFF} → divs_tvalid high exactly 4 cycles, single handshake; LO=0xFFFFFFFD, HI=0xFFFFFFFF; busy_stall drops on the done cycle.
- divu accepted, flush 5 cycles after handshake → DRAIN; a new mult requested during DRAIN keeps busy_stall=1; the divider result arrives with hl_we=0; mult is accepted the cycle after return to IDLE.
- mthi 0x12345678 then mtlo 0x9ABCDEF0 back-to-back → hl_we=10 then 01, done each cycle, busy_stall=0 throughout.
- reset asserted in DIV_WAIT → next cycle IDLE, all outputs 0; req_valid with flush=1 in IDLE → not accepted, no tvalid.

Source files
------------

// File: rtl/mdu_ctrl.sv
// Sequencer for the EXE-stage multiply/divide unit: multiplier latency count,
// divider AXI-stream handshakes, HI/LO write port, and flush/drain handling.
module mdu_ctrl #(
  parameter int unsigned MUL_STAGES = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  input  logic [2:0]  req_op,
  input  logic [31:0] req_src1,
  input  logic [31:0] req_src2,
  input  logic        flush,
  output logic        busy_stall,
  output logic        done,
  output logic [31:0] op_a,
  output logic [31:0] op_b,
  output logic        mul_signed,
  input  logic [63:0] mul_prod,
  output logic        divs_tvalid,
  input  logic        divs_tready,
  input  logic        divs_dout_valid,
  input  logic [63:0] divs_dout,
  output logic        divu_tvalid,
  input  logic        divu_tready,
  input  logic        divu_dout_valid,
  input  logic [63:0] divu_dout,
  output logic [1:0]  hl_we,
  output logic [31:0] hi_wdata,
  output logic [31:0] lo_wdata
);

  localparam int unsigned CNT_W = 3;

  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_MUL_WAIT = 3'd1;
  localparam logic [2:0] S_DIV_SEND = 3'd2;
  localparam logic [2:0] S_DIV_WAIT = 3'd3;
  localparam logic [2:0] S_DRAIN    = 3'd4;

  localparam logic [2:0] OP_MULT  = 3'b001;
  localparam logic [2:0] OP_MULTU = 3'b010;
  localparam logic [2:0] OP_DIV   = 3'b011;
  localparam logic [2:0] OP_DIVU  = 3'b100;
  localparam logic [2:0] OP_MTHI  = 3'b101;
  localparam logic [2:0] OP_MTLO  = 3'b110;

  logic [2:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [31:0]      src1_q, src2_q;
  logic             signed_q, divu_q;
  logic             latch_en;

  logic        is_mul, is_div, is_mt, accept;
  logic        sel_tready, sel_dv;
  logic [63:0] sel_dout;

  logic        busy_c, done_c;
  logic [1:0]  hl_we_c;
  logic [31:0] hi_c, lo_c;

  assign is_mul = (req_op == OP_MULT) || (req_op == OP_MULTU);
  assign is_div = (req_op == OP_DIV) || (req_op == OP_DIVU);
  assign is_mt  = (req_op == OP_MTHI) || (req_op == OP_MTLO);
  assign accept = req_valid && !flush && (is_mul || is_div || is_mt);

  // Everything divider-side follows the divider chosen at acceptance
  assign sel_tready = divu_q ? divu_tready     : divs_tready;
  assign sel_dv     = divu_q ? divu_dout_valid : divs_dout_valid;
  assign sel_dout   = divu_q ? divu_dout       : divs_dout;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      src1_q   <= '0;
      src2_q   <= '0;
      signed_q <= 1'b0;
      divu_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (latch_en) begin
        src1_q   <= req_src1;
        src2_q   <= req_src2;
        signed_q <= (req_op == OP_MULT);
        divu_q   <= (req_op == OP_DIVU);
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    latch_en = 1'b0;
    busy_c   = 1'b0;
    done_c   = 1'b0;
    hl_we_c  = 2'b00;
    hi_c     = '0;
    lo_c     = '0;

    case (state_q)
      S_IDLE: begin
        if (accept) begin
          if (is_mul) begin
            busy_c   = 1'b1;
            latch_en = 1'b1;
            cnt_d    = CNT_W'(MUL_STAGES - 1);
            state_d  = S_MUL_WAIT;
          end else if (is_div) begin
            busy_c   = 1'b1;
            latch_en = 1'b1;
            state_d  = S_DIV_SEND;
          end else begin
            done_c = 1'b1;
            if (req_op == OP_MTHI) begin
              hl_we_c = 2'b10;
              hi_c    = req_src1;
            end else begin
              hl_we_c = 2'b01;
              lo_c    = req_src1;
            end
          end
        end
      end

      S_MUL_WAIT: begin
        busy_c = (cnt_q != '0);
        if (flush) begin
          state_d = S_IDLE;
        end else if (cnt_q == '0) begin
          done_c  = 1'b1;
          hl_we_c = 2'b11;
          hi_c    = mul_prod[63:32];
          lo_c    = mul_prod[31:0];
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end

      S_DIV_SEND: begin
        busy_c = 1'b1;
        if (sel_tready) begin
          state_d = flush ? S_DRAIN : S_DIV_WAIT;
        end else if (flush) begin
          state_d = S_IDLE;
        end
      end

      S_DIV_WAIT: begin
        busy_c = !sel_dv;
        // A result landing on the flush cycle is already drained, so skip DRAIN
        if (sel_dv) begin
          state_d = S_IDLE;
          if (!flush) begin
            done_c  = 1'b1;
            hl_we_c = 2'b11;
            hi_c    = sel_dout[31:0];
            lo_c    = sel_dout[63:32];
          end
        end else if (flush) begin
          state_d = S_DRAIN;
        end
      end

      S_DRAIN: begin
        busy_c = req_valid;
        if (sel_dv) begin
          state_d = S_IDLE;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Outputs are forced quiet while reset is held
  assign busy_stall  = !reset && busy_c;
  assign done        = !reset && done_c;
  assign hl_we       = reset ? 2'b00 : hl_we_c;
  assign hi_wdata    = reset ? 32'd0 : hi_c;
  assign lo_wdata    = reset ? 32'd0 : lo_c;
  assign op_a        = reset ? 32'd0 : ((state_q == S_IDLE) ? req_src1 : src1_q);
  assign op_b        = reset ? 32'd0 : ((state_q == S_IDLE) ? req_src2 : src2_q);
  assign mul_signed  = !reset && ((state_q == S_IDLE) ? (req_op == OP_MULT) : signed_q);
  assign divs_tvalid = !reset && (state_q == S_DIV_SEND) && !divu_q;
  assign divu_tvalid = !reset && (state_q == S_DIV_SEND) && divu_q;

endmodule
